// File: rtl/button_debouncer_if.sv
// Button debouncer port bundle: sample tick and raw buttons in, clean levels and pulses out.
// The debouncer takes the slave side; whoever drives buttons/tick takes the master side.
interface button_debouncer_if #(
    parameter int N_BTN = 4
);
    logic             Enable;
    logic [N_BTN-1:0] Btn_raw;
    logic [N_BTN-1:0] Btn_level;
    logic [N_BTN-1:0] Btn_press;
    logic [N_BTN-1:0] Btn_release;
    logic [N_BTN-1:0] Btn_repeat;

    modport master (
        output Enable,
        output Btn_raw,
        input  Btn_level,
        input  Btn_press,
        input  Btn_release,
        input  Btn_repeat
    );

    modport slave (
        input  Enable,
        input  Btn_raw,
        output Btn_level,
        output Btn_press,
        output Btn_release,
        output Btn_repeat
    );
endinterface

// File: rtl/button_debouncer.sv
// Purpose: per-button debounce, press/release edge pulses and auto-repeat, sampled on the Enable tick.
// Latency: 2 CLK synchronizer + STABLE_TICKS ticks to Btn_level; all pulses are registered, 1 CLK wide.
// Backpressure: none; outputs are fire-and-forget, Enable=0 freezes every counter and level.
module button_debouncer #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 20
) (
    input  logic              CLK,
    input  logic              Reset,
    button_debouncer_if.slave bif
);

    localparam int SW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2
    } rep_state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] release_vec;
    logic [N_BTN-1:0] repeat_vec;

    // Synchronizer runs every CLK; only sync2 feeds the debounce logic.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bif.Btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [SW-1:0] stab_cnt;
        logic [SW-1:0] stab_cnt_nxt;
        logic          level;
        logic          rise;
        logic          fall;
        rep_state_t    state;
        rep_state_t    state_nxt;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_cnt_nxt;
        logic          rep_nxt;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;

        // A single agreeing sample restarts the stability count.
        always_comb begin
            stab_cnt_nxt = stab_cnt;
            rise         = 1'b0;
            fall         = 1'b0;
            if (bif.Enable) begin
                if (sync2[i] == level) begin
                    stab_cnt_nxt = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    stab_cnt_nxt = '0;
                    rise         = ~level;
                    fall         = level;
                end else begin
                    stab_cnt_nxt = stab_cnt + 1'b1;
                end
            end
        end

        // Repeat fires when the hold count reaches its terminal value on this tick,
        // so the first repeat lands exactly REPEAT_DELAY ticks after the press.
        always_comb begin
            state_nxt    = state;
            hold_cnt_nxt = hold_cnt;
            rep_nxt      = 1'b0;
            if (bif.Enable) begin
                case (state)
                    RELEASED: begin
                        if (rise) begin
                            state_nxt    = DELAY;
                            hold_cnt_nxt = '0;
                        end
                    end
                    DELAY: begin
                        if (fall) begin
                            state_nxt    = RELEASED;
                            hold_cnt_nxt = '0;
                        end else if (hold_cnt == DELAY_LAST) begin
                            state_nxt    = REPEAT;
                            hold_cnt_nxt = '0;
                            rep_nxt      = 1'b1;
                        end else begin
                            hold_cnt_nxt = hold_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (fall) begin
                            state_nxt    = RELEASED;
                            hold_cnt_nxt = '0;
                        end else if (hold_cnt == RATE_LAST) begin
                            hold_cnt_nxt = '0;
                            rep_nxt      = 1'b1;
                        end else begin
                            hold_cnt_nxt = hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt    = RELEASED;
                        hold_cnt_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK) begin
            if (Reset) begin
                stab_cnt  <= '0;
                level     <= 1'b0;
                state     <= RELEASED;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                stab_cnt  <= stab_cnt_nxt;
                level     <= level ^ (rise | fall);
                state     <= state_nxt;
                hold_cnt  <= hold_cnt_nxt;
                press_q   <= rise;
                release_q <= fall;
                repeat_q  <= rep_nxt;
            end
        end

        assign level_vec[i]   = level;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign repeat_vec[i]  = repeat_q;
    end

    assign bif.Btn_level   = level_vec;
    assign bif.Btn_press   = press_vec;
    assign bif.Btn_release = release_vec;
    assign bif.Btn_repeat  = repeat_vec;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: cycle-level vector table with Enable stuck high,
// then tick-spaced sequences for press, bounce, auto-repeat, simultaneous and reset cases.
module tb_button_debouncer;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    button_debouncer_if #(.N_BTN(4)) bif ();

    button_debouncer #(
        .N_BTN(4),
        .STABLE_TICKS(4),
        .REPEAT_DELAY(100),
        .REPEAT_RATE(20)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bif(bif)
    );

    int errors = 0;
    int checks = 0;
    int stray  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] rpt;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic r, input logic en, input logic [3:0] raw);
        @(negedge CLK);
        Reset       = r;
        bif.Enable  = en;
        bif.Btn_raw = raw;
        @(posedge CLK);
        #1;
    endtask

    // Nine idle CLKs (synchronizer settles) then one Enable CLK; outputs sampled after the tick edge.
    task automatic tick(input logic [3:0] raw);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, raw);
            if ((bif.Btn_press | bif.Btn_release | bif.Btn_repeat) != 4'h0) stray++;
        end
        cyc(1'b0, 1'b1, raw);
    endtask

    initial begin
        int bad;
        int presses;
        logic [3:0] exp_rpt;
        logic bounce[8];

        bif.Enable  = 1'b0;
        bif.Btn_raw = 4'h0;

        // Reset with raw=F and Enable pulsing, then Enable stuck high with Btn_raw[1].
        vt[0]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[1]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[2]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[3]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[4]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[5]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[6]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[7]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[8]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[9]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        vt[10] = '{1'b0, 1'b1, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        vt[11] = '{1'b0, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};

        for (int v = 0; v < 12; v++) begin
            cyc(vt[v].rst, vt[v].en, vt[v].raw);
            chk($sformatf("vec%0d level", v),   32'(bif.Btn_level),   32'(vt[v].lvl));
            chk($sformatf("vec%0d press", v),   32'(bif.Btn_press),   32'(vt[v].prs));
            chk($sformatf("vec%0d release", v), 32'(bif.Btn_release), 32'(vt[v].rel));
            chk($sformatf("vec%0d repeat", v),  32'(bif.Btn_repeat),  32'(vt[v].rpt));
        end

        // Stuck Enable: first repeat 100 CLK after the press (press edge was vt[10]).
        bad = 0;
        for (int c = 2; c < 100; c++) begin
            cyc(1'b0, 1'b1, 4'h2);
            if (bif.Btn_repeat != 4'h0) bad++;
        end
        chk("stuck early repeats", 32'(bad), 32'd0);
        cyc(1'b0, 1'b1, 4'h2);
        chk("stuck repeat at 100", 32'(bif.Btn_repeat), 32'h2);
        cyc(1'b0, 1'b1, 4'h2);
        chk("stuck repeat width", 32'(bif.Btn_repeat), 32'h0);

        // Enable low freezes level even though the raw input has dropped.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 1'b0, 4'h0);
            if (bif.Btn_level != 4'h2 || (bif.Btn_press | bif.Btn_release | bif.Btn_repeat) != 4'h0) bad++;
        end
        chk("freeze hold", 32'(bad), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            cyc(1'b0, 1'b1, 4'h0);
            chk($sformatf("unfreeze level c%0d", c), 32'(bif.Btn_level), 32'h2);
        end
        cyc(1'b0, 1'b1, 4'h0);
        chk("unfreeze release", 32'(bif.Btn_release), 32'h2);
        chk("unfreeze level low", 32'(bif.Btn_level), 32'h0);
        chk("unfreeze no repeat", 32'(bif.Btn_repeat), 32'h0);

        // Clean press and release on button 0.
        stray = 0;
        for (int k = 1; k <= 4; k++) begin
            tick(4'h1);
            chk($sformatf("clean t%0d level", k), 32'(bif.Btn_level), (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("clean t%0d press", k), 32'(bif.Btn_press), (k == 4) ? 32'h1 : 32'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(4'h0);
            chk($sformatf("clean rel t%0d", k), 32'(bif.Btn_release), (k == 4) ? 32'h1 : 32'h0);
        end

        // Bounce on button 1: no run of four equal samples.
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            tick(bounce[k] ? 4'h2 : 4'h0);
            chk($sformatf("bounce t%0d", k),
                32'({bif.Btn_level, bif.Btn_press, bif.Btn_release}), 32'h0);
        end
        presses = 0;
        for (int k = 1; k <= 4; k++) begin
            tick(4'h2);
            if (bif.Btn_press[1]) presses++;
        end
        chk("bounce settle level", 32'(bif.Btn_level), 32'h2);
        chk("bounce single press", 32'(presses), 32'd1);
        for (int k = 1; k <= 4; k++) tick(4'h0);
        chk("bounce release", 32'(bif.Btn_release), 32'h2);

        // Auto-repeat on button 2 across 200 held ticks.
        for (int k = 1; k <= 4; k++) tick(4'h4);
        chk("repeat press", 32'(bif.Btn_press), 32'h4);
        for (int k = 1; k <= 200; k++) begin
            tick(4'h4);
            exp_rpt = (k >= 100 && (k % 20) == 0) ? 4'h4 : 4'h0;
            chk($sformatf("repeat t%0d", k), 32'(bif.Btn_repeat), 32'(exp_rpt));
        end
        for (int k = 1; k <= 4; k++) begin
            tick(4'h0);
            chk($sformatf("repeat rel t%0d", k), 32'({bif.Btn_release, bif.Btn_repeat}),
                (k == 4) ? 32'h40 : 32'h0);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick(4'h0);
            if (bif.Btn_repeat != 4'h0) bad++;
        end
        chk("no repeat after release", 32'(bad), 32'd0);

        // Simultaneous press of buttons 3 and 0, then reset while in REPEAT.
        for (int k = 1; k <= 4; k++) begin
            tick(4'h9);
            chk($sformatf("simul t%0d press", k), 32'(bif.Btn_press), (k == 4) ? 32'h9 : 32'h0);
        end
        for (int k = 1; k <= 105; k++) begin
            tick(4'h9);
            if (k == 100) chk("simul repeat", 32'(bif.Btn_repeat), 32'h9);
        end
        cyc(1'b1, 1'b1, 4'h9);
        chk("reset outputs a", 32'({bif.Btn_level, bif.Btn_press, bif.Btn_release, bif.Btn_repeat}), 32'h0);
        cyc(1'b1, 1'b0, 4'h9);
        chk("reset outputs b", 32'({bif.Btn_level, bif.Btn_press, bif.Btn_release, bif.Btn_repeat}), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick(4'h9);
            chk($sformatf("post-reset t%0d level", k), 32'(bif.Btn_level), (k == 4) ? 32'h9 : 32'h0);
            chk($sformatf("post-reset t%0d press", k), 32'(bif.Btn_press), (k == 4) ? 32'h9 : 32'h0);
        end
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            tick(4'h9);
            if (k < 100 && bif.Btn_repeat != 4'h0) bad++;
            if (k == 100) chk("post-reset first repeat", 32'(bif.Btn_repeat), 32'h9);
        end
        chk("post-reset no early repeat", 32'(bad), 32'd0);

        chk("no pulses between ticks", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
